// File: rtl/time_entry_loader.sv
// Keypad front end for the countdown timer: collects an M:SS entry, normalises the
// seconds on START, issues a one-cycle active-low parallel load and tracks run state.
module time_entry_loader #(
  parameter logic [3:0]  START_CODE = 4'hA,
  parameter logic [3:0]  CLEAR_CODE = 4'hB,
  parameter int unsigned MAX_MIN    = 9
) (
  input  logic       clock,
  input  logic       clr,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       timer_done,
  output logic       loadn,
  output logic [3:0] data_min,
  output logic [3:0] data_tens,
  output logic [3:0] data_ones,
  output logic       running,
  output logic       cancel,
  output logic [1:0] digit_count
);

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned COUNT_W = 2;
  localparam logic [DIGIT_W-1:0] MAX_MIN_D  = DIGIT_W'(MAX_MIN);
  localparam logic [DIGIT_W-1:0] TENS_LIMIT = DIGIT_W'(5);
  localparam logic [DIGIT_W-1:0] TENS_WRAP  = DIGIT_W'(6);
  localparam logic [DIGIT_W-1:0] ONES_MAX   = DIGIT_W'(9);
  localparam logic [COUNT_W-1:0] COUNT_MAX  = COUNT_W'(3);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ENTRY   = 2'd1,
    S_LOAD    = 2'd2,
    S_RUNNING = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [DIGIT_W-1:0] min_q, min_d;
  logic [DIGIT_W-1:0] tens_q, tens_d;
  logic [DIGIT_W-1:0] ones_q, ones_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               loadn_q, loadn_d;
  logic               running_q, running_d;
  logic               cancel_q, cancel_d;

  logic is_digit;
  logic is_start;
  logic is_clear;
  logic digits_zero;

  // Key decode; anything outside 0-9, START and CLEAR falls through all three
  always_comb begin
    is_digit    = key_valid && (key_code <= ONES_MAX);
    is_start    = key_valid && (key_code == START_CODE);
    is_clear    = key_valid && (key_code == CLEAR_CODE);
    digits_zero = (min_q == '0) && (tens_q == '0) && (ones_q == '0);
  end

  // State register
  always_ff @(posedge clock) begin
    if (clr) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (is_digit) begin
          state_d = S_ENTRY;
        end
      end
      S_ENTRY: begin
        if (is_digit) begin
          state_d = S_ENTRY;
        end else if (is_clear) begin
          state_d = S_IDLE;
        end else if (is_start && !digits_zero) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        state_d = S_RUNNING;
      end
      S_RUNNING: begin
        if (timer_done || is_clear) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output / datapath next values
  always_comb begin
    min_d     = min_q;
    tens_d    = tens_q;
    ones_d    = ones_q;
    count_d   = count_q;
    cancel_d  = 1'b0;
    loadn_d   = (state_d != S_LOAD);
    running_d = (state_d == S_RUNNING);
    unique case (state_q)
      S_IDLE, S_ENTRY: begin
        if (is_digit) begin
          min_d  = tens_q;
          tens_d = ones_q;
          ones_d = key_code;
          if (count_q != COUNT_MAX) begin
            count_d = count_q + COUNT_W'(1);
          end
        end else if (is_clear) begin
          min_d   = '0;
          tens_d  = '0;
          ones_d  = '0;
          count_d = '0;
        end else if (is_start && (state_q == S_ENTRY) && !digits_zero) begin
          // Fold a seconds-tens of 6+ into the minutes, clamping at MAX_MIN:59
          if (tens_q > TENS_LIMIT) begin
            if (min_q < MAX_MIN_D) begin
              tens_d = tens_q - TENS_WRAP;
              min_d  = min_q + DIGIT_W'(1);
            end else begin
              min_d  = MAX_MIN_D;
              tens_d = TENS_LIMIT;
              ones_d = ONES_MAX;
            end
          end
        end
      end
      S_LOAD: begin
      end
      S_RUNNING: begin
        if (timer_done || is_clear) begin
          min_d    = '0;
          tens_d   = '0;
          ones_d   = '0;
          count_d  = '0;
          cancel_d = !timer_done;
        end
      end
      default: begin
      end
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clock) begin
    if (clr) begin
      min_q     <= '0;
      tens_q    <= '0;
      ones_q    <= '0;
      count_q   <= '0;
      loadn_q   <= 1'b1;
      running_q <= 1'b0;
      cancel_q  <= 1'b0;
    end else begin
      min_q     <= min_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      count_q   <= count_d;
      loadn_q   <= loadn_d;
      running_q <= running_d;
      cancel_q  <= cancel_d;
    end
  end

  assign loadn       = loadn_q;
  assign data_min    = min_q;
  assign data_tens   = tens_q;
  assign data_ones   = ones_q;
  assign running     = running_q;
  assign cancel      = cancel_q;
  assign digit_count = count_q;

endmodule

// File: tb/tb_time_entry_loader.sv
// Directed bench for time_entry_loader: load and cancel events go through a
// scoreboard queue checked by a monitor; static outputs are checked inline.
module tb_time_entry_loader;

  localparam logic [3:0] K_START = 4'hA;
  localparam logic [3:0] K_CLEAR = 4'hB;
  localparam logic [1:0] EV_LOAD   = 2'd1;
  localparam logic [1:0] EV_CANCEL = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [11:0] data;
  } ev_t;

  logic       clock = 1'b0;
  logic       clr = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic       timer_done = 1'b0;
  logic       loadn;
  logic [3:0] data_min, data_tens, data_ones;
  logic       running, cancel;
  logic [1:0] digit_count;

  int n_vec = 0;
  int n_err = 0;
  ev_t exp_q[$];

  time_entry_loader dut (
    .clock       (clock),
    .clr         (clr),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .timer_done  (timer_done),
    .loadn       (loadn),
    .data_min    (data_min),
    .data_tens   (data_tens),
    .data_ones   (data_ones),
    .running     (running),
    .cancel      (cancel),
    .digit_count (digit_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic press(input logic [3:0] code);
    @(negedge clock);
    key_valid = 1'b1;
    key_code  = code;
    @(negedge clock);
    key_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic expect_ev(input logic [1:0] kind, input logic [11:0] data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic chk_state(input string name, input logic [11:0] digits,
                           input logic [1:0] cnt, input logic run);
    chk({name, "_digits"}, {20'h0, data_min, data_tens, data_ones}, {20'h0, digits});
    chk({name, "_count"}, {30'h0, digit_count}, {30'h0, cnt});
    chk({name, "_running"}, {31'h0, running}, {31'h0, run});
  endtask

  // Monitor: every load strobe or cancel pulse must match the next queued event
  always @(negedge clock) begin
    if (loadn === 1'b0 || cancel === 1'b1) begin
      ev_t obs, e;
      obs.kind = (loadn === 1'b0) ? EV_LOAD : EV_CANCEL;
      obs.data = (loadn === 1'b0) ? {data_min, data_tens, data_ones} : 12'h000;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_event: got kind %0d data %03h expected none", obs.kind, obs.data);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e) begin
          n_err++;
          $display("FAIL event: got kind %0d data %03h expected kind %0d data %03h",
                   obs.kind, obs.data, e.kind, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset
    @(negedge clock);
    clr = 1'b1;
    idle_cycles(2);
    clr = 1'b0;
    chk_state("reset", 12'h000, 2'd0, 1'b0);
    chk("reset_loadn", {31'h0, loadn}, 32'h1);
    chk("reset_cancel", {31'h0, cancel}, 32'h0);

    // 1,3,0 START -> load 1:3:0
    press(4'd1);
    chk_state("first_key", 12'h001, 2'd1, 1'b0);
    press(4'd3);
    press(4'd0);
    chk_state("entry_130", 12'h130, 2'd3, 1'b0);
    press(4'hC);
    chk_state("undef_key", 12'h130, 2'd3, 1'b0);
    expect_ev(EV_LOAD, 12'h130);
    press(K_START);
    @(negedge clock);
    chk_state("run_130", 12'h130, 2'd3, 1'b1);
    chk("run_loadn", {31'h0, loadn}, 32'h1);
    @(negedge clock);
    timer_done = 1'b1;
    @(negedge clock);
    timer_done = 1'b0;
    chk_state("done_130", 12'h000, 2'd0, 1'b0);

    // 7,5 START -> 0:75 normalised to 1:15
    press(4'd7);
    press(4'd5);
    chk_state("entry_075", 12'h075, 2'd2, 1'b0);
    expect_ev(EV_LOAD, 12'h115);
    press(K_START);
    @(negedge clock);
    chk_state("run_115", 12'h115, 2'd2, 1'b1);
    @(negedge clock);
    timer_done = 1'b1;
    @(negedge clock);
    timer_done = 1'b0;

    // 9,8,0 START -> clamped to 9:59
    press(4'd9);
    press(4'd8);
    press(4'd0);
    expect_ev(EV_LOAD, 12'h959);
    press(K_START);
    @(negedge clock);
    chk_state("run_959", 12'h959, 2'd3, 1'b1);
    @(negedge clock);
    timer_done = 1'b1;
    @(negedge clock);
    timer_done = 1'b0;
    chk_state("done_959", 12'h000, 2'd0, 1'b0);

    // 1,2,3,4 then CLEAR
    press(4'd1);
    press(4'd2);
    press(4'd3);
    press(4'd4);
    chk_state("entry_234", 12'h234, 2'd3, 1'b0);
    press(K_CLEAR);
    chk_state("clear_entry", 12'h000, 2'd0, 1'b0);
    chk("clear_no_cancel", {31'h0, cancel}, 32'h0);

    // START in IDLE, then 0,0 START: no load ever
    press(K_START);
    press(4'd0);
    press(4'd0);
    press(K_START);
    idle_cycles(3);
    chk_state("zero_start", 12'h000, 2'd2, 1'b0);
    press(K_CLEAR);

    // Running: digit and START ignored, CLEAR cancels
    press(4'd2);
    press(4'd0);
    press(4'd0);
    expect_ev(EV_LOAD, 12'h200);
    press(K_START);
    @(negedge clock);
    press(4'd5);
    press(K_START);
    chk_state("run_ignore", 12'h200, 2'd3, 1'b1);
    expect_ev(EV_CANCEL, 12'h000);
    press(K_CLEAR);
    chk_state("cancelled", 12'h000, 2'd0, 1'b0);
    @(negedge clock);
    chk("cancel_one_cycle", {31'h0, cancel}, 32'h0);

    // timer_done and CLEAR together: no cancel
    press(4'd3);
    press(4'd0);
    expect_ev(EV_LOAD, 12'h030);
    press(K_START);
    @(negedge clock);
    @(negedge clock);
    key_valid  = 1'b1;
    key_code   = K_CLEAR;
    timer_done = 1'b1;
    @(negedge clock);
    key_valid  = 1'b0;
    timer_done = 1'b0;
    chk_state("done_and_clear", 12'h000, 2'd0, 1'b0);
    chk("done_wins_cancel", {31'h0, cancel}, 32'h0);
    idle_cycles(2);

    // clr during the LOAD cycle
    press(4'd4);
    press(4'd5);
    expect_ev(EV_LOAD, 12'h045);
    @(negedge clock);
    key_valid = 1'b1;
    key_code  = K_START;
    @(negedge clock);
    key_valid = 1'b0;
    clr = 1'b1;
    @(negedge clock);
    clr = 1'b0;
    chk_state("clr_in_load", 12'h000, 2'd0, 1'b0);
    chk("clr_in_load_loadn", {31'h0, loadn}, 32'h1);
    idle_cycles(4);
    chk("after_clr_running", {31'h0, running}, 32'h0);

    chk("pending_events", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
